// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the RV32I memory stage.
// Holds the IDLE/BUSY request-controller state encoding and the default
// access timeout. The timeout only applies when MEM_ACCESS_TIMEOUT_EN is defined.
package mem_access_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/mem_access_dmem_req_ctrl.sv
// dmem_req_ctrl: data-memory request FSM for the memory stage.
// It latches a load/store when the access is accepted in IDLE. It then holds
// req/addr/data stable in BUSY until the memory acknowledges the access.
// When MEM_ACCESS_TIMEOUT_EN is defined, an 8-bit counter aborts an access
// after TIMEOUT_CYCLES unacknowledged BUSY cycles.
module dmem_req_ctrl
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_access,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_wr_en,
  input  logic [4:0]  i_reg_dst,
  input  logic        i_mem_to_reg,
  input  logic        i_reg_wr_en,
  input  logic        i_ack,
  output logic        o_req,
  output logic        o_wr_en,
  output logic [31:0] o_addr,
  output logic [31:0] o_wr_data,
  output logic [31:0] o_latched_addr,
  output logic [4:0]  o_reg_dst,
  output logic        o_mem_to_reg,
  output logic        o_reg_wr_en,
  output logic        o_idle,
  output logic        o_done,
  output logic        o_abort,
  output logic        o_stall
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  reg_dst_q, reg_dst_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic        busy;
  logic        abort;

  assign busy = (state_q == BUSY);

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] timeout_last = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  // Count unacknowledged BUSY cycles, restarting for every newly accepted access
  always_comb begin
    cnt_d = cnt_q;
    if (!busy && i_access) begin
      cnt_d = 8'd0;
    end else if (busy && !i_ack) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign abort = busy && !i_ack && (cnt_q == timeout_last);
`else
  localparam logic [7:0] timeout_cfg = 8'(TIMEOUT_CYCLES);

  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^timeout_cfg;
  assign abort = 1'b0;
`endif

  // Next state: capture the access in IDLE, leave BUSY on ack or abort
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = wr_en_q;
    reg_dst_d    = reg_dst_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_wr_en_d  = reg_wr_en_q;
    case (state_q)
      IDLE: begin
        if (i_access) begin
          state_d      = BUSY;
          addr_d       = i_addr;
          wr_data_d    = i_wr_data;
          wr_en_d      = i_wr_en;
          reg_dst_d    = i_reg_dst;
          mem_to_reg_d = i_mem_to_reg;
          reg_wr_en_d  = i_reg_wr_en;
        end
      end
      BUSY: begin
        if (i_ack || abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and request latches; reset clears the request immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      wr_data_q    <= 32'd0;
      wr_en_q      <= 1'b0;
      reg_dst_q    <= 5'd0;
      mem_to_reg_q <= 1'b0;
      reg_wr_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_wr_en_q  <= reg_wr_en_d;
    end
  end

  assign o_req          = busy;
  assign o_wr_en        = wr_en_q;
  assign o_addr         = {addr_q[31:2], 2'b00};
  assign o_wr_data      = wr_data_q;
  assign o_latched_addr = addr_q;
  assign o_reg_dst      = reg_dst_q;
  assign o_mem_to_reg   = mem_to_reg_q;
  assign o_reg_wr_en    = reg_wr_en_q;
  assign o_idle         = !busy;
  assign o_done         = busy && i_ack;
  assign o_abort        = abort;
  assign o_stall        = (!busy && i_access) || (busy && !i_ack && !abort);

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage of the light RV32I five-stage pipeline.
// It resolves branch/jump redirects and drives the MEM/WB register.
// Word loads and stores are handed to dmem_req_ctrl, which runs the
// req/ack handshake. The optional abort-on-timeout is built only when
// MEM_ACCESS_TIMEOUT_EN is defined.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pipe_Valid,
  input  logic [31:0] i_pipe_TargetAddr,
  input  logic [31:0] i_pipe_AluResult,
  input  logic        i_pipe_Zero,
  input  logic [31:0] i_pipe_Reg2Data,
  input  logic [4:0]  i_pipe_RegDst,
  input  logic        i_pipe_MemToReg,
  input  logic        i_pipe_RegWrEn,
  input  logic        i_pipe_MemWrEn,
  input  logic        i_pipe_Branch,
  input  logic        i_pipe_Jump,
  output logic        o_Stall,
  output logic        o_PcSrc,
  output logic [31:0] o_BranchTarget,
  output logic        o_dmem_Req,
  output logic        o_dmem_WrEn,
  output logic [31:0] o_dmem_Addr,
  output logic [31:0] o_dmem_WrData,
  input  logic        i_dmem_Ack,
  input  logic [31:0] i_dmem_RdData,
  output logic        o_pipe_Valid,
  output logic        o_pipe_MemToReg,
  output logic        o_pipe_RegWrEn,
  output logic        o_pipe_Fault,
  output logic [31:0] o_pipe_AluResult,
  output logic [31:0] o_pipe_MemData,
  output logic [4:0]  o_pipe_RegDst
);

  logic        access;
  logic        ctrl_wr_en;
  logic [31:0] ctrl_addr;
  logic [4:0]  ctrl_reg_dst;
  logic        ctrl_mem_to_reg;
  logic        ctrl_reg_wr_en;
  logic        ctrl_idle;
  logic        ctrl_done;
  logic        ctrl_abort;

  logic        valid_q, valid_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic        fault_q, fault_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [4:0]  reg_dst_q, reg_dst_d;

  assign access = i_pipe_Valid && (i_pipe_MemToReg || i_pipe_MemWrEn);

  assign o_PcSrc        = i_pipe_Valid && (i_pipe_Jump || (i_pipe_Branch && i_pipe_Zero));
  assign o_BranchTarget = i_pipe_TargetAddr;

  dmem_req_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ctrl (
    .clk           (clk),
    .reset         (reset),
    .i_access      (access),
    .i_addr        (i_pipe_AluResult),
    .i_wr_data     (i_pipe_Reg2Data),
    .i_wr_en       (i_pipe_MemWrEn),
    .i_reg_dst     (i_pipe_RegDst),
    .i_mem_to_reg  (i_pipe_MemToReg),
    .i_reg_wr_en   (i_pipe_RegWrEn),
    .i_ack         (i_dmem_Ack),
    .o_req         (o_dmem_Req),
    .o_wr_en       (ctrl_wr_en),
    .o_addr        (o_dmem_Addr),
    .o_wr_data     (o_dmem_WrData),
    .o_latched_addr(ctrl_addr),
    .o_reg_dst     (ctrl_reg_dst),
    .o_mem_to_reg  (ctrl_mem_to_reg),
    .o_reg_wr_en   (ctrl_reg_wr_en),
    .o_idle        (ctrl_idle),
    .o_done        (ctrl_done),
    .o_abort       (ctrl_abort),
    .o_stall       (o_Stall)
  );

  assign o_dmem_WrEn = ctrl_wr_en;

  // MEM/WB next value: completed access, aborted access, pass-through, else bubble
  always_comb begin
    valid_d      = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_wr_en_d  = 1'b0;
    fault_d      = 1'b0;
    alu_result_d = 32'd0;
    mem_data_d   = 32'd0;
    reg_dst_d    = 5'd0;
    if (ctrl_done) begin
      valid_d      = 1'b1;
      mem_to_reg_d = ctrl_mem_to_reg;
      reg_wr_en_d  = ctrl_reg_wr_en;
      alu_result_d = ctrl_addr;
      mem_data_d   = ctrl_wr_en ? 32'd0 : i_dmem_RdData;
      reg_dst_d    = ctrl_reg_dst;
    end else if (ctrl_abort) begin
      valid_d      = 1'b1;
      fault_d      = 1'b1;
      mem_to_reg_d = ctrl_mem_to_reg;
      alu_result_d = ctrl_addr;
      reg_dst_d    = ctrl_reg_dst;
    end else if (ctrl_idle && !access) begin
      valid_d      = i_pipe_Valid;
      mem_to_reg_d = i_pipe_Valid && i_pipe_MemToReg;
      reg_wr_en_d  = i_pipe_Valid && i_pipe_RegWrEn;
      alu_result_d = i_pipe_AluResult;
      reg_dst_d    = i_pipe_RegDst;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_wr_en_q  <= 1'b0;
      fault_q      <= 1'b0;
      alu_result_q <= 32'd0;
      mem_data_q   <= 32'd0;
      reg_dst_q    <= 5'd0;
    end else begin
      valid_q      <= valid_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_wr_en_q  <= reg_wr_en_d;
      fault_q      <= fault_d;
      alu_result_q <= alu_result_d;
      mem_data_q   <= mem_data_d;
      reg_dst_q    <= reg_dst_d;
    end
  end

  assign o_pipe_Valid     = valid_q;
  assign o_pipe_MemToReg  = mem_to_reg_q;
  assign o_pipe_RegWrEn   = reg_wr_en_q;
  assign o_pipe_Fault     = fault_q;
  assign o_pipe_AluResult = alu_result_q;
  assign o_pipe_MemData   = mem_data_q;
  assign o_pipe_RegDst    = reg_dst_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for the mem_access memory stage.
// Inputs change 1 time unit after the rising edge.
// Outputs are sampled 2 units after the rising edge, well away from the active edge.
module tb_mem_access;

  logic        clk;
  logic        reset;
  logic        i_pipe_Valid;
  logic [31:0] i_pipe_TargetAddr;
  logic [31:0] i_pipe_AluResult;
  logic        i_pipe_Zero;
  logic [31:0] i_pipe_Reg2Data;
  logic [4:0]  i_pipe_RegDst;
  logic        i_pipe_MemToReg;
  logic        i_pipe_RegWrEn;
  logic        i_pipe_MemWrEn;
  logic        i_pipe_Branch;
  logic        i_pipe_Jump;
  logic        o_Stall;
  logic        o_PcSrc;
  logic [31:0] o_BranchTarget;
  logic        o_dmem_Req;
  logic        o_dmem_WrEn;
  logic [31:0] o_dmem_Addr;
  logic [31:0] o_dmem_WrData;
  logic        i_dmem_Ack;
  logic [31:0] i_dmem_RdData;
  logic        o_pipe_Valid;
  logic        o_pipe_MemToReg;
  logic        o_pipe_RegWrEn;
  logic        o_pipe_Fault;
  logic [31:0] o_pipe_AluResult;
  logic [31:0] o_pipe_MemData;
  logic [4:0]  o_pipe_RegDst;

  int passed;
  int total;

  mem_access #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_pipe_Valid     (i_pipe_Valid),
    .i_pipe_TargetAddr(i_pipe_TargetAddr),
    .i_pipe_AluResult (i_pipe_AluResult),
    .i_pipe_Zero      (i_pipe_Zero),
    .i_pipe_Reg2Data  (i_pipe_Reg2Data),
    .i_pipe_RegDst    (i_pipe_RegDst),
    .i_pipe_MemToReg  (i_pipe_MemToReg),
    .i_pipe_RegWrEn   (i_pipe_RegWrEn),
    .i_pipe_MemWrEn   (i_pipe_MemWrEn),
    .i_pipe_Branch    (i_pipe_Branch),
    .i_pipe_Jump      (i_pipe_Jump),
    .o_Stall          (o_Stall),
    .o_PcSrc          (o_PcSrc),
    .o_BranchTarget   (o_BranchTarget),
    .o_dmem_Req       (o_dmem_Req),
    .o_dmem_WrEn      (o_dmem_WrEn),
    .o_dmem_Addr      (o_dmem_Addr),
    .o_dmem_WrData    (o_dmem_WrData),
    .i_dmem_Ack       (i_dmem_Ack),
    .i_dmem_RdData    (i_dmem_RdData),
    .o_pipe_Valid     (o_pipe_Valid),
    .o_pipe_MemToReg  (o_pipe_MemToReg),
    .o_pipe_RegWrEn   (o_pipe_RegWrEn),
    .o_pipe_Fault     (o_pipe_Fault),
    .o_pipe_AluResult (o_pipe_AluResult),
    .o_pipe_MemData   (o_pipe_MemData),
    .o_pipe_RegDst    (o_pipe_RegDst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    i_pipe_Valid      = 1'b0;
    i_pipe_TargetAddr = 32'd0;
    i_pipe_AluResult  = 32'd0;
    i_pipe_Zero       = 1'b0;
    i_pipe_Reg2Data   = 32'd0;
    i_pipe_RegDst     = 5'd0;
    i_pipe_MemToReg   = 1'b0;
    i_pipe_RegWrEn    = 1'b0;
    i_pipe_MemWrEn    = 1'b0;
    i_pipe_Branch     = 1'b0;
    i_pipe_Jump       = 1'b0;
    i_dmem_Ack        = 1'b0;
    i_dmem_RdData     = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    total++; if (o_dmem_Req !== 1'b0) $display("[TB] FAIL reset_req: got %b want 0", o_dmem_Req); else passed++;
    total++; if ({o_dmem_Addr, o_dmem_WrData, o_dmem_WrEn} !== 65'd0) $display("[TB] FAIL reset_dmem: addr %h data %h wren %b want 0", o_dmem_Addr, o_dmem_WrData, o_dmem_WrEn); else passed++;
    total++; if ({o_pipe_Valid, o_pipe_MemToReg, o_pipe_RegWrEn, o_pipe_Fault, o_pipe_AluResult, o_pipe_MemData, o_pipe_RegDst} !== 73'd0) $display("[TB] FAIL reset_memwb: valid %b alu %h mem %h dst %0d want 0", o_pipe_Valid, o_pipe_AluResult, o_pipe_MemData, o_pipe_RegDst); else passed++;
    total++; if ({o_Stall, o_PcSrc} !== 2'b00) $display("[TB] FAIL reset_comb: stall/pcsrc %b want 00", {o_Stall, o_PcSrc}); else passed++;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_alu();
    next_cycle();
    i_pipe_Valid     = 1'b1;
    i_pipe_AluResult = 32'h0000_1234;
    i_pipe_RegDst    = 5'd5;
    i_pipe_RegWrEn   = 1'b1;
    #1;
    total++; if (o_Stall !== 1'b0) $display("[TB] FAIL alu_stall: got %b want 0", o_Stall); else passed++;
    next_cycle();
    clear_inputs();
    #1;
    total++; if ({o_pipe_Valid, o_pipe_RegWrEn, o_pipe_MemToReg, o_pipe_Fault} !== 4'b1100) $display("[TB] FAIL alu_ctrl: got %b want 1100", {o_pipe_Valid, o_pipe_RegWrEn, o_pipe_MemToReg, o_pipe_Fault}); else passed++;
    total++; if (o_pipe_AluResult !== 32'h0000_1234) $display("[TB] FAIL alu_result: got %h want 00001234", o_pipe_AluResult); else passed++;
    total++; if (o_pipe_MemData !== 32'd0) $display("[TB] FAIL alu_memdata: got %h want 0", o_pipe_MemData); else passed++;
    total++; if (o_pipe_RegDst !== 5'd5) $display("[TB] FAIL alu_regdst: got %0d want 5", o_pipe_RegDst); else passed++;
    total++; if ({o_Stall, o_dmem_Req} !== 2'b00) $display("[TB] FAIL alu_after: stall/req %b want 00", {o_Stall, o_dmem_Req}); else passed++;
  endtask

  task automatic test_load();
    int stall_cycles;
    stall_cycles = 0;
    i_pipe_Valid     = 1'b1;
    i_pipe_AluResult = 32'h0000_0100;
    i_pipe_MemToReg  = 1'b1;
    i_pipe_RegWrEn   = 1'b1;
    i_pipe_RegDst    = 5'd7;
    #1;
    if (o_Stall === 1'b1) stall_cycles++;
    total++; if (o_dmem_Req !== 1'b0) $display("[TB] FAIL load_req_c0: got %b want 0", o_dmem_Req); else passed++;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      i_dmem_Ack    = (c == 3);
      i_dmem_RdData = (c == 3) ? 32'hDEAD_BEEF : 32'h5555_5555;
      #1;
      if (o_Stall === 1'b1) stall_cycles++;
      total++; if ({o_dmem_Req, o_dmem_WrEn, o_dmem_Addr} !== {2'b10, 32'h0000_0100}) $display("[TB] FAIL load_dmem_c%0d: req %b wren %b addr %h want 1 0 00000100", c, o_dmem_Req, o_dmem_WrEn, o_dmem_Addr); else passed++;
    end
    total++; if (o_Stall !== 1'b0) $display("[TB] FAIL load_stall_ack: got %b want 0", o_Stall); else passed++;
    total++; if (stall_cycles != 3) $display("[TB] FAIL load_stall_count: got %0d want 3", stall_cycles); else passed++;
    next_cycle();
    clear_inputs();
    #1;
    total++; if (o_pipe_MemData !== 32'hDEAD_BEEF) $display("[TB] FAIL load_memdata: got %h want deadbeef", o_pipe_MemData); else passed++;
    total++; if ({o_pipe_Valid, o_pipe_RegWrEn, o_pipe_MemToReg, o_pipe_Fault, o_pipe_RegDst} !== {4'b1110, 5'd7}) $display("[TB] FAIL load_memwb: v/rw/m2r/f %b dst %0d want 1110 7", {o_pipe_Valid, o_pipe_RegWrEn, o_pipe_MemToReg, o_pipe_Fault}, o_pipe_RegDst); else passed++;
    total++; if (o_dmem_Req !== 1'b0) $display("[TB] FAIL load_req_done: got %b want 0", o_dmem_Req); else passed++;
  endtask

  task automatic test_store();
    i_pipe_Valid     = 1'b1;
    i_pipe_AluResult = 32'h0000_0207;
    i_pipe_Reg2Data  = 32'hCAFE_F00D;
    i_pipe_MemWrEn   = 1'b1;
    i_pipe_RegDst    = 5'd9;
    #1;
    total++; if (o_Stall !== 1'b1) $display("[TB] FAIL store_stall_c0: got %b want 1", o_Stall); else passed++;
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      i_pipe_Reg2Data = 32'h0BAD_0BAD;
      i_dmem_Ack      = (c == 2);
      i_dmem_RdData   = 32'h1111_1111;
      #1;
      total++; if ({o_dmem_Req, o_dmem_WrEn, o_dmem_Addr, o_dmem_WrData} !== {2'b11, 32'h0000_0204, 32'hCAFE_F00D}) $display("[TB] FAIL store_dmem_c%0d: req %b wren %b addr %h data %h want 1 1 00000204 cafef00d", c, o_dmem_Req, o_dmem_WrEn, o_dmem_Addr, o_dmem_WrData); else passed++;
    end
    next_cycle();
    clear_inputs();
    #1;
    total++; if ({o_pipe_Valid, o_pipe_RegWrEn, o_pipe_Fault} !== 3'b100) $display("[TB] FAIL store_memwb: v/rw/f %b want 100", {o_pipe_Valid, o_pipe_RegWrEn, o_pipe_Fault}); else passed++;
    total++; if (o_pipe_MemData !== 32'd0) $display("[TB] FAIL store_memdata: got %h want 0", o_pipe_MemData); else passed++;
  endtask

  task automatic test_branch();
    i_pipe_Valid      = 1'b1;
    i_pipe_Branch     = 1'b1;
    i_pipe_Zero       = 1'b1;
    i_pipe_TargetAddr = 32'h0000_0040;
    #1;
    total++; if ({o_PcSrc, o_Stall, o_BranchTarget} !== {2'b10, 32'h0000_0040}) $display("[TB] FAIL branch_taken: pcsrc %b stall %b tgt %h want 1 0 00000040", o_PcSrc, o_Stall, o_BranchTarget); else passed++;
    i_pipe_Zero = 1'b0;
    #1;
    total++; if (o_PcSrc !== 1'b0) $display("[TB] FAIL branch_not_taken: got %b want 0", o_PcSrc); else passed++;
    i_pipe_Branch = 1'b0;
    i_pipe_Jump   = 1'b1;
    #1;
    total++; if (o_PcSrc !== 1'b1) $display("[TB] FAIL jump: got %b want 1", o_PcSrc); else passed++;
    i_pipe_Valid = 1'b0;
    #1;
    total++; if (o_PcSrc !== 1'b0) $display("[TB] FAIL jump_invalid: got %b want 0", o_PcSrc); else passed++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_ack_idle();
    i_pipe_Valid     = 1'b1;
    i_pipe_AluResult = 32'h0000_0042;
    i_dmem_Ack       = 1'b1;
    i_dmem_RdData    = 32'h7777_7777;
    next_cycle();
    clear_inputs();
    #1;
    total++; if ({o_pipe_Valid, o_pipe_RegWrEn, o_pipe_MemData, o_pipe_AluResult} !== {2'b10, 32'd0, 32'h0000_0042}) $display("[TB] FAIL ack_idle: v %b rw %b mem %h alu %h want 1 0 0 00000042", o_pipe_Valid, o_pipe_RegWrEn, o_pipe_MemData, o_pipe_AluResult); else passed++;
    total++; if (o_dmem_Req !== 1'b0) $display("[TB] FAIL ack_idle_req: got %b want 0", o_dmem_Req); else passed++;
  endtask

  task automatic test_back_to_back();
    i_pipe_Valid     = 1'b1;
    i_pipe_MemToReg  = 1'b1;
    i_pipe_RegWrEn   = 1'b1;
    i_pipe_AluResult = 32'h0000_0300;
    i_pipe_RegDst    = 5'd3;
    next_cycle();
    i_dmem_Ack    = 1'b1;
    i_dmem_RdData = 32'hAAAA_0001;
    #1;
    total++; if ({o_dmem_Req, o_Stall} !== 2'b10) $display("[TB] FAIL b2b_first_ack: req/stall %b want 10", {o_dmem_Req, o_Stall}); else passed++;
    next_cycle();
    i_dmem_Ack       = 1'b0;
    i_pipe_AluResult = 32'h0000_0304;
    i_pipe_RegDst    = 5'd4;
    #1;
    total++; if ({o_dmem_Req, o_Stall, o_pipe_Valid, o_pipe_MemData} !== {3'b011, 32'hAAAA_0001}) $display("[TB] FAIL b2b_accept: req %b stall %b v %b mem %h want 0 1 1 aaaa0001", o_dmem_Req, o_Stall, o_pipe_Valid, o_pipe_MemData); else passed++;
    next_cycle();
    i_dmem_Ack    = 1'b1;
    i_dmem_RdData = 32'hBBBB_0002;
    #1;
    total++; if ({o_dmem_Req, o_dmem_Addr, o_pipe_Valid} !== {1'b1, 32'h0000_0304, 1'b0}) $display("[TB] FAIL b2b_second_req: req %b addr %h v %b want 1 00000304 0", o_dmem_Req, o_dmem_Addr, o_pipe_Valid); else passed++;
    next_cycle();
    clear_inputs();
    #1;
    total++; if ({o_pipe_Valid, o_pipe_MemData, o_pipe_RegDst} !== {1'b1, 32'hBBBB_0002, 5'd4}) $display("[TB] FAIL b2b_second_data: v %b mem %h dst %0d want 1 bbbb0002 4", o_pipe_Valid, o_pipe_MemData, o_pipe_RegDst); else passed++;
  endtask

  task automatic test_timeout();
    i_pipe_Valid     = 1'b1;
    i_pipe_MemToReg  = 1'b1;
    i_pipe_RegWrEn   = 1'b1;
    i_pipe_AluResult = 32'h0000_0500;
    i_pipe_RegDst    = 5'd11;
`ifdef MEM_ACCESS_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      #1;
      total++; if ({o_dmem_Req, o_Stall} !== {1'b1, (c < 4)}) $display("[TB] FAIL timeout_c%0d: req/stall %b want 1%b", c, {o_dmem_Req, o_Stall}, (c < 4)); else passed++;
    end
    next_cycle();
    clear_inputs();
    i_dmem_Ack    = 1'b1;
    i_dmem_RdData = 32'h9999_9999;
    #1;
    total++; if ({o_pipe_Valid, o_pipe_Fault, o_pipe_RegWrEn, o_pipe_MemData} !== {3'b110, 32'd0}) $display("[TB] FAIL timeout_memwb: v %b f %b rw %b mem %h want 1 1 0 0", o_pipe_Valid, o_pipe_Fault, o_pipe_RegWrEn, o_pipe_MemData); else passed++;
    total++; if ({o_dmem_Req, o_Stall} !== 2'b00) $display("[TB] FAIL timeout_release: req/stall %b want 00", {o_dmem_Req, o_Stall}); else passed++;
    next_cycle();
    i_dmem_Ack = 1'b0;
    #1;
    total++; if ({o_pipe_Valid, o_pipe_Fault, o_pipe_MemData} !== {2'b00, 32'd0}) $display("[TB] FAIL timeout_late_ack: v %b f %b mem %h want 0 0 0", o_pipe_Valid, o_pipe_Fault, o_pipe_MemData); else passed++;
`else
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      #1;
      total++; if ({o_dmem_Req, o_Stall, o_pipe_Valid} !== 3'b110) $display("[TB] FAIL no_timeout_c%0d: req/stall/v %b want 110", c, {o_dmem_Req, o_Stall, o_pipe_Valid}); else passed++;
    end
    next_cycle();
    i_dmem_Ack    = 1'b1;
    i_dmem_RdData = 32'h1234_5678;
    next_cycle();
    clear_inputs();
    #1;
    total++; if ({o_pipe_Valid, o_pipe_Fault, o_pipe_RegWrEn, o_pipe_MemData} !== {3'b101, 32'h1234_5678}) $display("[TB] FAIL no_timeout_done: v %b f %b rw %b mem %h want 1 0 1 12345678", o_pipe_Valid, o_pipe_Fault, o_pipe_RegWrEn, o_pipe_MemData); else passed++;
`endif
  endtask

  task automatic test_reset_mid_access();
    i_pipe_Valid     = 1'b1;
    i_pipe_MemWrEn   = 1'b1;
    i_pipe_AluResult = 32'h0000_0600;
    i_pipe_Reg2Data  = 32'h0000_00FF;
    next_cycle();
    clear_inputs();
    #1;
    total++; if (o_dmem_Req !== 1'b1) $display("[TB] FAIL rstmid_req_before: got %b want 1", o_dmem_Req); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({o_dmem_Req, o_Stall, o_dmem_Addr, o_dmem_WrData, o_dmem_WrEn} !== 67'd0) $display("[TB] FAIL rstmid_dmem: req %b stall %b addr %h data %h wren %b want 0", o_dmem_Req, o_Stall, o_dmem_Addr, o_dmem_WrData, o_dmem_WrEn); else passed++;
    total++; if ({o_pipe_Valid, o_pipe_RegWrEn, o_pipe_Fault, o_pipe_AluResult, o_pipe_MemData} !== 67'd0) $display("[TB] FAIL rstmid_memwb: v %b alu %h mem %h want 0", o_pipe_Valid, o_pipe_AluResult, o_pipe_MemData); else passed++;
    next_cycle();
    reset = 1'b0;
    i_dmem_Ack    = 1'b1;
    i_dmem_RdData = 32'h3333_3333;
    next_cycle();
    i_dmem_Ack = 1'b0;
    #1;
    total++; if ({o_dmem_Req, o_pipe_Valid, o_pipe_MemData} !== {2'b00, 32'd0}) $display("[TB] FAIL rstmid_late_ack: req %b v %b mem %h want 0 0 0", o_dmem_Req, o_pipe_Valid, o_pipe_MemData); else passed++;
  endtask

  // Run every scenario in order, then print the pass summary
  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_ack_idle();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
